// File: rtl/crc_pkg.sv
// Shared CRC-6 definitions for the serial CRC transmitter and its matching receiver/checker.
// Both ends must call crc6() from here so that they always agree on the polynomial.
package crc_pkg;

    localparam int CRC_W      = 6;
    localparam int DATA_W     = 8;
    localparam int FRAME_BITS = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_CRC   = 3'd3,
        ST_STOP  = 3'd4
    } tx_state_e;

    // The seed is already folded into the inverted terms, so no register initialisation is needed.
    function automatic logic [CRC_W-1:0] crc6(input logic [DATA_W-1:0] d);
        logic [CRC_W-1:0] c;
        c[0] = ~(d[5] ^ d[2] ^ d[1] ^ d[0]);
        c[1] =   d[6] ^ d[5] ^ d[3] ^ d[0];
        c[2] =   d[7] ^ d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0];
        c[3] =   d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0];
        c[4] = ~(d[7] ^ d[4] ^ d[3] ^ d[1]);
        c[5] = ~(d[4] ^ d[1] ^ d[0]);
        return c;
    endfunction

endpackage

// File: rtl/gen_crc_tx_if.sv
// Byte-in handshake and serial-out status bundle of the CRC transmitter.
// The producer uses the master modport and the transmitter uses the slave modport.
interface gen_crc_tx_if;
    import crc_pkg::*;

    logic [DATA_W-1:0] d_in;
    logic              d_valid;
    logic              d_ready;
    logic              tx_out;
    logic [CRC_W-1:0]  tx_crc;
    logic              tx_busy;
    logic              tx_done;

    modport master (
        output d_in, d_valid,
        input  d_ready, tx_out, tx_crc, tx_busy, tx_done
    );

    modport slave (
        input  d_in, d_valid,
        output d_ready, tx_out, tx_crc, tx_busy, tx_done
    );

endinterface

// File: rtl/gen_crc_tx_bit_timer.sv
// Per-bit cycle counter: it counts 0..CLKS_PER_BIT-1 while enabled and flags the last cycle of each bit.
// While disabled it is held at zero, so the first bit of a frame always gets a full period.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_tick
);

    localparam int              CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d    = '0;
        bit_tick = 1'b0;
        if (en) begin
            if (cnt_q == CNT_LAST) begin
                bit_tick = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gen_crc_tx.sv
// Serial transmitter that sends one byte per frame: start, d[0..7], crc[0..5], stop, LSB first.
// Every output is registered, so the start bit appears on the same edge that accepts the byte.
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | line high, ready to accept a byte
// ST_START | start bit (0) on the line
// ST_DATA  | data bits d[0]..d[7], bit_idx selects the current bit
// ST_CRC   | CRC bits crc[0]..crc[5], bit_idx selects the current bit
// ST_STOP  | stop bit (1); tx_done pulses on the way back to idle
module gen_crc_tx
    import crc_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    gen_crc_tx_if.slave  bus
);

    tx_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CRC_W-1:0]  crc_q, crc_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic              tx_out_q, tx_out_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              timer_en;
    logic              bit_tick;

    assign timer_en = (state_q != ST_IDLE);

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (timer_en),
        .bit_tick (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        crc_d     = crc_q;
        bit_idx_d = bit_idx_q;
        tx_out_d  = tx_out_q;
        ready_d   = ready_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // ready_q is low for the first idle cycle after reset, so no byte is taken before it rises.
                if (bus.d_valid && ready_q) begin
                    state_d   = ST_START;
                    data_d    = bus.d_in;
                    crc_d     = crc6(bus.d_in);
                    bit_idx_d = 3'd0;
                    tx_out_d  = 1'b0;
                    ready_d   = 1'b0;
                    busy_d    = 1'b1;
                end else begin
                    ready_d   = 1'b1;
                    tx_out_d  = 1'b1;
                end
            end

            ST_START: begin
                if (bit_tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = 3'd0;
                    tx_out_d  = data_q[0];
                end
            end

            ST_DATA: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d   = ST_CRC;
                        bit_idx_d = 3'd0;
                        tx_out_d  = crc_q[0];
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_out_d  = data_q[bit_idx_q + 3'd1];
                    end
                end
            end

            ST_CRC: begin
                if (bit_tick) begin
                    if (bit_idx_q == 3'd5) begin
                        state_d   = ST_STOP;
                        bit_idx_d = 3'd0;
                        tx_out_d  = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_out_d  = crc_q[bit_idx_q + 3'd1];
                    end
                end
            end

            ST_STOP: begin
                if (bit_tick) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = 3'd0;
                    tx_out_d  = 1'b1;
                    ready_d   = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = 3'd0;
                tx_out_d  = 1'b1;
                ready_d   = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            crc_q     <= '0;
            bit_idx_q <= '0;
            tx_out_q  <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            crc_q     <= crc_d;
            bit_idx_q <= bit_idx_d;
            tx_out_q  <= tx_out_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.d_ready = ready_q;
    assign bus.tx_out  = tx_out_q;
    assign bus.tx_crc  = crc_q;
    assign bus.tx_busy = busy_q;
    assign bus.tx_done = done_q;

endmodule

// File: tb/tb_gen_crc_tx.sv
// Scoreboard bench for gen_crc_tx: dut_a runs at 4 clocks/bit and dut_b runs at 1 clock/bit.
// The stimulus pushes the hand-computed frame for each byte; a negedge monitor pops and checks it.
module tb_gen_crc_tx;

    typedef struct {
        logic [7:0]  d;
        logic [5:0]  crc;
        logic [15:0] line;
        bit          b2b;
    } exp_t;

    logic clk;
    logic rst_n_a;
    logic rst_n_b;

    int total;
    int bad;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    exp_t cur[2];
    bit   act[2];
    bit   pdone[2];
    bit   pb2b[2];
    int   cyc[2];
    int   cpb[2];

    logic       o_out[2];
    logic       o_ready[2];
    logic       o_busy[2];
    logic       o_done[2];
    logic       o_rst[2];
    logic [5:0] o_crc[2];

    gen_crc_tx_if bus_a();
    gen_crc_tx_if bus_b();

    gen_crc_tx #(.CLKS_PER_BIT(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n_a),
        .bus   (bus_a)
    );

    gen_crc_tx #(.CLKS_PER_BIT(1)) dut_b (
        .clk   (clk),
        .rst_n (rst_n_b),
        .bus   (bus_b)
    );

    assign o_out[0]   = bus_a.tx_out;
    assign o_out[1]   = bus_b.tx_out;
    assign o_ready[0] = bus_a.d_ready;
    assign o_ready[1] = bus_b.d_ready;
    assign o_busy[0]  = bus_a.tx_busy;
    assign o_busy[1]  = bus_b.tx_busy;
    assign o_done[0]  = bus_a.tx_done;
    assign o_done[1]  = bus_b.tx_done;
    assign o_crc[0]   = bus_a.tx_crc;
    assign o_crc[1]   = bus_b.tx_crc;
    assign o_rst[0]   = rst_n_a;
    assign o_rst[1]   = rst_n_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act_v, input int exp_v);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act_v, exp_v, $time);
        end
    endtask

    task automatic mon_step(input int k);
        logic [3:0] bi;
        if (!o_rst[k]) begin
            act[k]   = 1'b0;
            pdone[k] = 1'b0;
            pb2b[k]  = 1'b0;
            return;
        end
        if (pdone[k]) begin
            chk("done_pulse", int'(o_done[k]), 1);
            chk("done_busy", int'(o_busy[k]), 0);
            chk("done_line", int'(o_out[k]), 1);
            chk("crc_hold", int'(o_crc[k]), int'(cur[k].crc));
            pb2b[k]  = cur[k].b2b;
            pdone[k] = 1'b0;
            return;
        end
        if (pb2b[k]) begin
            chk("b2b_restart", int'(o_busy[k]), 1);
            pb2b[k] = 1'b0;
        end
        if (!act[k]) begin
            chk("no_done", int'(o_done[k]), 0);
            if (o_busy[k]) begin
                if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame dut%0d: busy=1 want no frame", k);
                end else begin
                    cur[k] = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                    act[k] = 1'b1;
                    cyc[k] = 0;
                end
            end
        end
        if (act[k]) begin
            bi = 4'(cyc[k] / cpb[k]);
            chk("line_bit", int'(o_out[k]), int'(cur[k].line[bi]));
            chk("crc_frame", int'(o_crc[k]), int'(cur[k].crc));
            chk("busy_frame", int'(o_busy[k]), 1);
            cyc[k]++;
            if (cyc[k] == 16 * cpb[k]) begin
                act[k]   = 1'b0;
                pdone[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        mon_step(0);
        mon_step(1);
    end

    task automatic drive(input int k, input logic v, input logic [7:0] d);
        if (k == 0) begin
            bus_a.d_valid = v;
            bus_a.d_in    = d;
        end else begin
            bus_b.d_valid = v;
            bus_b.d_in    = d;
        end
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic [5:0] c,
                        input bit b2b, input bit hold);
        exp_t e;
        int   n;
        e.d    = d;
        e.crc  = c;
        e.line = {1'b1, c, d, 1'b0};
        e.b2b  = b2b;
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        @(negedge clk);
        drive(k, 1'b1, d);
        n = 0;
        while (!o_ready[k] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            total++;
            bad++;
            $display("FAIL accept_timeout dut%0d: d_ready=0 want 1", k);
            drive(k, 1'b0, d);
            return;
        end
        @(posedge clk);
        @(negedge clk);
        if (!hold) drive(k, 1'b0, d);
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        cpb[0]  = 4;
        cpb[1]  = 1;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_line", int'(bus_a.tx_out), 1);
        chk("rst_ready", int'(bus_a.d_ready), 0);
        chk("rst_busy", int'(bus_a.tx_busy), 0);
        chk("rst_crc", int'(bus_a.tx_crc), 0);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_line", int'(bus_a.tx_out), 1);
            chk("idle_ready", int'(bus_a.d_ready), 1);
            chk("idle_busy", int'(bus_a.tx_busy), 0);
            chk("idle_crc", int'(bus_a.tx_crc), 0);
        end

        send(0, 8'h00, 6'h31, 1'b0, 1'b0);
        send(0, 8'hFF, 6'h19, 1'b0, 1'b0);

        // Back-to-back: d_valid stays high across the first frame while d_in already shows the next byte.
        send(0, 8'hA5, 6'h08, 1'b1, 1'b1);
        drive(0, 1'b1, 8'h3C);
        send(0, 8'h3C, 6'h15, 1'b0, 1'b0);

        // This frame is aborted by reset during cycle 30, so the monitor never sees its tx_done.
        send(0, 8'hA5, 6'h08, 1'b0, 1'b0);
        repeat (29) @(posedge clk);
        #2 rst_n_a = 1'b0;
        #1;
        chk("abort_line", int'(bus_a.tx_out), 1);
        chk("abort_busy", int'(bus_a.tx_busy), 0);
        chk("abort_done", int'(bus_a.tx_done), 0);
        chk("abort_ready", int'(bus_a.d_ready), 0);
        chk("abort_crc", int'(bus_a.tx_crc), 0);
        repeat (3) @(negedge clk);
        rst_n_a = 1'b1;
        @(negedge clk);
        chk("rel_ready", int'(bus_a.d_ready), 1);
        chk("rel_busy", int'(bus_a.tx_busy), 0);
        send(0, 8'h5A, 6'h20, 1'b0, 1'b0);

        send(1, 8'h5A, 6'h20, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, 1'b0, (i % 2 == 0) ? 8'hA5 : 8'hFF);
        end

        n = 0;
        while ((exp_q0.size() != 0 || exp_q1.size() != 0 || act[0] || act[1] ||
                pdone[0] || pdone[1] || pb2b[0] || pb2b[1]) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", exp_q0.size() + exp_q1.size());
        end
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gen_crc_tx.md
GEN_CRC_TX -- requirements
Module: gen_crc_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 d_in  input  8  payload byte, sampled on handshake.
REQ-005 d_valid  input  1  producer has a byte on d_in.
REQ-006 d_ready  output  1  block can accept a byte this cycle.
REQ-007 tx_out  output  1  serial frame line, idle high.
REQ-008 tx_crc  output  6  CRC-6 of the frame in flight or last sent.
REQ-009 tx_busy  output  1  frame in progress.
REQ-010 tx_done  output  1  one-cycle pulse at frame end.

Function
REQ-011 Handshake: byte accepted at the rising edge where d_valid=1 and d_ready=1; d_ready SHALL be 1 only in IDLE.
REQ-012 On acceptance: d_in latched; tx_crc loaded in the same edge with CRC6(d_in).
REQ-013 CRC6, seed folded in, d=data byte (^ = XOR, ~ = invert):
  crc[0]=~(d5^d2^d1^d0); crc[1]=d6^d5^d3^d0; crc[2]=d7^d6^d5^d4^d2^d0;
  crc[3]=d7^d6^d3^d2^d0; crc[4]=~(d7^d4^d3^d1); crc[5]=~(d4^d1^d0).
REQ-014 Frame, 16 bits: start(0), d[0]..d[7], crc[0]..crc[5], stop(1); each bit held exactly CLKS_PER_BIT cycles.
REQ-015 FSM states: IDLE -> START (on handshake) -> DATA (8 bits) -> CRC (6 bits) -> STOP -> IDLE; no other transitions except reset.
REQ-016 Latency: tx_out drives start bit from the edge that accepts the byte; frame occupies 16*CLKS_PER_BIT cycles.
REQ-017 tx_busy=1 in START, DATA, CRC, STOP; 0 in IDLE.
REQ-018 tx_done=1 for exactly the one cycle after the last STOP cycle, coinciding with first IDLE cycle.
REQ-019 d_valid during busy SHALL be ignored; d_in changes after acceptance SHALL NOT affect frame or tx_crc.
REQ-020 Back-to-back: d_valid held high gives one IDLE cycle (line high) between consecutive stop and start bits.
REQ-021 Bit timer counts 0..CLKS_PER_BIT-1 and wraps; bit index counts 0..7 in DATA, 0..5 in CRC, resets on state change.
REQ-022 CLKS_PER_BIT=1: each bit one cycle, no lost or duplicated bits.
REQ-023 tx_crc SHALL hold its value after the frame until the next acceptance.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, tx_out=1, d_ready=0, tx_busy=0, tx_done=0, tx_crc=0, counters=0, independent of clk.
REQ-025 Reset mid-frame SHALL abort the frame with no tx_done; d_ready=1 from first clk edge after rst_n rises.

Structure
REQ-026 Shared package crc_pkg: CRC6 function (REQ-013), CRC_W=6, DATA_W=8, FRAME_BITS=16, FSM state enum; the matching receiver/checker SHALL use the same function.
REQ-027 One sub-module bit_timer (parameter CLKS_PER_BIT; outputs bit_tick at count wrap); FSM and shift logic in gen_crc_tx.

Verification
REQ-028 Reset release, no valid -> tx_out=1, d_ready=1, tx_busy=0, tx_crc=0x00 indefinitely.
REQ-029 d_in=0x00, CLKS_PER_BIT=4 -> tx_crc=0x31; line 0,00000000,100011,1 over 64 cycles; tx_done at cycle 64.
REQ-030 d_in=0xFF -> tx_crc=0x19; d_in=0xA5 -> tx_crc=0x08; serial CRC bits LSB-first match.
REQ-031 d_valid held high, bytes 0xA5 then 0x3C -> two frames, exactly one idle-high cycle between; second byte accepted on that cycle.
REQ-032 rst_n low at cycle 30 of a frame -> tx_out=1 same cycle, no tx_done; next byte framed correctly after release.
REQ-033 CLKS_PER_BIT=1, d_in=0x5A -> 16-cycle frame, each bit one cycle, d_in toggled mid-frame has no effect.
